// File: rtl/slr_pkg.sv
// Shared types and defaults for the sequential logical-shift-right controller.
package slr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } slr_state_t;

    localparam int SLR_W = 4;

endpackage

// File: rtl/slr_step.sv
// Single-position logical right shift; the MSB is zero-filled.
import slr_pkg::*;

module slr_step #(
    parameter int WIDTH = SLR_W
) (
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    assign q = d >> 1;

endmodule

// File: rtl/slr_seq_ctrl.sv
// Handshaked controller that shifts A right by B, one bit position per clock.
import slr_pkg::*;

module slr_seq_ctrl #(
    parameter int WIDTH = SLR_W,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] c,
    output logic             busy
);

    localparam logic [WIDTH-1:0] B_MAX = WIDTH'(WIDTH);

    slr_state_t       state;
    slr_state_t       state_nxt;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] data_nxt;
    logic [WIDTH-1:0] step_q;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [CW-1:0]    amt;

    slr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .d(data),
        .q(step_q)
    );

    // Compare the full amount before narrowing so large b never wraps.
    assign amt = (b >= B_MAX) ? CW'(WIDTH) : CW'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            data  <= '0;
            count <= '0;
        end else begin
            state <= state_nxt;
            data  <= data_nxt;
            count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        data_nxt  = data;
        count_nxt = count;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    data_nxt  = a;
                    count_nxt = amt;
                    state_nxt = (amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                data_nxt  = step_q;
                count_nxt = count - CW'(1);
                if (count == CW'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign c         = data;

endmodule

// File: tb/tb_slr_seq_ctrl.sv
// Directed bench for slr_seq_ctrl: vector table plus backpressure and reset sequences.
module tb_slr_seq_ctrl;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] c;
    logic         busy;

    int n_checks;
    int n_pass;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] c;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    slr_seq_ctrl #(
        .WIDTH(W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .a(a),
        .b(b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .c(c),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [W-1:0] ec, input int elat);
        int  lat;
        bit  rdy_low;
        chk("idle_ready", in_ready, 1);
        a         = va;
        b         = vb;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 1;
        rdy_low  = 1'b1;
        while (!out_valid && lat < 20) begin
            if (in_ready) rdy_low = 1'b0;
            tick();
            lat++;
        end
        chk("latency", lat, elat);
        chk("result_c", c, ec);
        chk("ready_low_busy", rdy_low && !in_ready && busy, 1);
        tick();
        chk("back_idle", {in_ready, out_valid, busy}, 3'b100);
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;

        vecs[0] = '{4'b1100, 4'd2,  4'b0011, 3};
        vecs[1] = '{4'b1011, 4'd0,  4'b1011, 1};
        vecs[2] = '{4'b1111, 4'd14, 4'b0000, 5};
        vecs[3] = '{4'b0110, 4'd1,  4'b0011, 2};
        vecs[4] = '{4'b1001, 4'd4,  4'b0000, 5};
        vecs[5] = '{4'b1111, 4'd3,  4'b0001, 4};
        vecs[6] = '{4'b1010, 4'd15, 4'b0000, 5};
        vecs[7] = '{4'b0101, 4'd5,  4'b0000, 5};
        vecs[8] = '{4'b1000, 4'd3,  4'b0001, 4};
        vecs[9] = '{4'b0111, 4'd1,  4'b0011, 2};

        #12;
        chk("reset_outputs", {in_ready, out_valid, busy, c}, 7'b1000000);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].lat);
        end

        // Backpressure with a second request held during busy.
        out_ready = 1'b0;
        a         = 4'b1000;
        b         = 4'd1;
        in_valid  = 1'b1;
        tick();
        a = 4'b0001;
        b = 4'd0;
        chk("bp_shift_busy", {in_ready, out_valid}, 2'b00);
        tick();
        chk("bp_valid_rise", out_valid, 1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_hold", {out_valid, in_ready, c}, {2'b10, 4'b0100});
            if (k < 2) tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_complete", {in_ready, out_valid}, 2'b10);
        tick();
        in_valid = 1'b0;
        chk("bp_second_c", {out_valid, c}, {1'b1, 4'b0001});
        tick();
        chk("bp_second_done", in_ready, 1);

        // Reset during the second SHIFT cycle.
        a        = 4'b1111;
        b        = 4'd3;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("mid_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_reset", {in_ready, out_valid, c}, {2'b10, 4'b0000});
        tick();
        rst_n = 1'b1;
        tick();
        do_op(4'b0110, 4'd1, 4'b0011, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
